// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone per-target round-robin arbiter.
package wb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } wb_arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: the first set req bit at or after rr_ptr, wrapping N-1 -> 0.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N_INITIATORS = 2,
  parameter int IW = clog2_min1(N_INITIATORS)
) (
  input  logic [N_INITIATORS-1:0] req,
  input  logic [IW-1:0]           rr_ptr,
  output logic [N_INITIATORS-1:0] pick,
  output logic [IW-1:0]           pick_id
);

  logic [IW-1:0] idx;

  // The scan runs from the farthest offset back to rr_ptr so the closest requester wins last.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    idx     = '0;
    for (int k = N_INITIATORS - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr) + k) % N_INITIATORS);
      if (req[idx]) begin
        pick      = '0;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

endmodule

// File: rtl/wb_target_arbiter.sv
// Per-target round-robin arbiter holding ownership for a whole Wishbone cycle.
// Optional watchdog with forced error and stale tracking: define WB_ARB_TIMEOUT_EN.
module wb_target_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_INITIATORS = 2,
  parameter int TIMEOUT      = 256,
  localparam int IW          = clog2_min1(N_INITIATORS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_INITIATORS-1:0] req,
  input  logic [N_INITIATORS-1:0] cyc,
  input  logic                    t_ack,
  input  logic                    t_err,
  output logic [N_INITIATORS-1:0] gnt,
  output logic [IW-1:0]           gnt_id,
  output logic                    gnt_vld,
  output logic                    to_err
);

  wb_arb_state_e           state;
  logic [IW-1:0]           rr_ptr;
  logic [N_INITIATORS-1:0] elig;
  logic [N_INITIATORS-1:0] pick;
  logic [IW-1:0]           pick_id;
  logic                    owner_cyc;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] id);
    if (int'(id) >= N_INITIATORS - 1) return '0;
    return id + 1'b1;
  endfunction

  assign owner_cyc = cyc[gnt_id];

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WW = clog2_min1(TIMEOUT);
  logic [WW-1:0]           wdog;
  logic [N_INITIATORS-1:0] stale;
  logic                    timeout;

  // An initiator that timed out stays ineligible until it drops cyc.
  assign elig    = req & ~stale;
  assign timeout = !(t_ack || t_err) && (wdog == WW'(TIMEOUT - 1));
`else
  logic unused_ok;
  assign elig      = req;
  assign to_err    = 1'b0;
  assign unused_ok = ^{t_ack, t_err};
`endif

  wb_rr_pick #(
    .N_INITIATORS(N_INITIATORS),
    .IW          (IW)
  ) u_pick (
    .req    (elig),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .pick_id(pick_id)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      gnt_vld <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      wdog    <= '0;
      stale   <= '0;
      to_err  <= 1'b0;
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      to_err <= 1'b0;
      stale  <= stale & cyc;
`endif
      case (state)
        IDLE: begin
          if (|elig) begin
            state   <= OWNED;
            gnt     <= pick;
            gnt_id  <= pick_id;
            gnt_vld <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            wdog    <= '0;
`endif
          end
        end
        OWNED: begin
          // Releasing initiator drops to lowest priority for the next round.
          if (!owner_cyc) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            rr_ptr  <= rr_next(gnt_id);
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (timeout) begin
            state         <= IDLE;
            gnt           <= '0;
            gnt_vld       <= 1'b0;
            rr_ptr        <= rr_next(gnt_id);
            to_err        <= 1'b1;
            stale[gnt_id] <= 1'b1;
          end else if (t_ack || t_err) begin
            wdog <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
